uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NREQ` byte requesters. It accepts one byte per grant, issues a single-cycle `tx_start` with the latched byte, and waits for `tx_done_tick`. It then reports completion to the granted requester and re-arbitrates. It sits between client logic (command responder, log streamer, etc.) and the `uart_tx` instance, sharing that instance's `clk` and `reset`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 200000: clk cycles allowed in WAIT before abort. Used only with `UART_TX_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `req` in NREQ: level request per requester.
- `din_flat` in NREQ*8: byte for requester i at bits [8i+7:8i].
- `ack` out NREQ: one-cycle pulse; byte of that requester latched.
- `done` out NREQ: one-cycle pulse; that requester's byte fully transmitted (or aborted).
- `tx_start` out 1: to `uart_tx.tx_start`.
- `tx_din` out 8: to `uart_tx.din`.
- `tx_done_tick` in 1: from `uart_tx.tx_done_tick`.
- `busy` out 1: high whenever state is not IDLE.
- `grant_id` out max(1,$clog2(NREQ)): index of current or last granted requester.
- `timeout_err` out 1: one-cycle pulse on WAIT abort.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `ack`, `done`, `tx_start`, `busy`, `timeout_err` all 0.
  - `tx_din` = 0, `grant_id` = 0.
  - Round-robin pointer `last` = NREQ-1, so requester 0 has top priority first.
- States:
  - IDLE: if `req` != 0, select the first set bit searching `last+1`, `last+2`, … modulo NREQ. Latch its byte into `tx_din`, set `grant_id`, set `last` to the winner, and go to ISSUE. If `req` = 0, stay in IDLE.
  - ISSUE (exactly 1 cycle): `tx_start` = 1 and `ack[grant_id]` = 1. Go to WAIT.
  - WAIT: on `tx_done_tick` = 1, go to IDLE; `done[grant_id]` pulses in the first IDLE cycle. Otherwise stay in WAIT.
- `tx_done_tick` outside WAIT is ignored.
- `req` is sampled only in IDLE. A requester keeps `req` and its data slice stable until `ack`. It may keep `req` high after `ack` to queue a next byte; that byte, with its data updated after `ack`, competes at the next IDLE.
- A requester holding `req` continuously cannot win twice in a row while another requester is waiting.
- `tx_din` holds its value from ISSUE until the next grant.
- Reset mid-operation: immediate return to reset values. No `done` is issued for the in-flight byte; the shared reset also clears `uart_tx`.

## Timing
- Cycle numbering:
  - `req` high in IDLE at cycle 0.
  - Cycle 1: ISSUE, with `tx_start` and `ack` high.
  - Cycle 2 onward: WAIT.
- `tx_done_tick` at cycle k → `done` and IDLE at k+1. The next grant's `tx_start` comes at k+2.
- `uart_tx` is back in its idle state by k+1, so it sees that `tx_start`.
- `busy` is high from cycle 1 through the cycle `tx_done_tick` is seen.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC-1 without `tx_done_tick`, the block goes to IDLE. In the next cycle, `done[grant_id]` and `timeout_err` pulse together.
  - If `tx_done_tick` and the timeout coincide, normal completion wins and `timeout_err` stays 0.
- Undefined: no counter is built, `timeout_err` is tied to 0, and WAIT is left only via `tx_done_tick`.

## Test plan
- Single request:
  - Stimulus: `req`=4'b0001, byte 8'hA5; `tx_done_tick` 20 cycles after `tx_start`.
  - Required: `tx_start` and `ack[0]` at cycle 1, `tx_din`=A5, `done[0]` one cycle after the tick, `busy` low afterwards.
- Simultaneous requests:
  - Stimulus: `req`=4'b1010 from reset.
  - Required: grant order 1 then 3, with each `ack`/`done` going only to the granted index.
- Continuous requests:
  - Stimulus: `req`=4'b1111 held, each byte completed by a tick.
  - Required: grant order 0,1,2,3,0,1; gap from each `tx_done_tick` to the next `tx_start` is exactly 2 cycles.
- Spurious tick:
  - Stimulus: `tx_done_tick` pulsed in IDLE and in the ISSUE cycle.
  - Required: no `done`, no state change.
- Reset mid-operation:
  - Stimulus: assert `reset` mid-WAIT.
  - Required: all outputs at reset values immediately, no `done`; after release, `req`=4'b1000 is granted to requester 3 with `grant_id`=3.
- Timeout:
  - Stimulus: with `UART_TX_ARB_TIMEOUT_EN` and TIMEOUT_CYC=50, send no tick.
  - Required: `timeout_err` and `done[grant_id]` pulse exactly once, 51 cycles after the ISSUE cycle; arbitration resumes.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NREQ byte requesters; optional WAIT watchdog under UART_TX_ARB_TIMEOUT_EN.
// Latency: req seen in IDLE -> tx_start/ack next cycle; tx_done_tick -> done next cycle, next tx_start one cycle later.
// Backpressure: requesters hold req and data until ack; req is only sampled in IDLE, one byte in flight at a time.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 200000,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   din_flat,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     done,
    output logic                tx_start,
    output logic [7:0]          tx_din,
    input  logic                tx_done_tick,
    output logic                busy,
    output logic [IDW-1:0]      grant_id,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  grant_d;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            found;
    logic [7:0]      din_arr [NREQ];
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] ack_d;
    logic [NREQ-1:0] done_d;
    logic [7:0]      tx_din_d;
    logic            tx_start_d;
    logic            busy_d;
    logic            timeout_d;
    logic            timeout_hit;

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            din_arr[i] = din_flat[i*8 +: 8];
        end
    end

    // Round-robin search starting just after the last winner, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        for (int off = 0; off < NREQ; off++) begin
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // One-hot decode of the new winner (for ack) and the current grant (for done).
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i]   = (win == IDW'(i));
            grant_oh[i] = (grant_id == IDW'(i));
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;

    // WAIT-cycle counter: cleared while issuing so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_id;
        tx_din_d   = tx_din;
        ack_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_ISSUE;
                    last_d     = win;
                    grant_d    = win;
                    tx_din_d   = din_arr[win];
                    ack_d      = win_oh;
                    tx_start_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Real completion takes precedence over a coincident timeout.
                if (tx_done_tick) begin
                    state_d = S_IDLE;
                    done_d  = grant_oh;
                end else if (timeout_hit) begin
                    state_d   = S_IDLE;
                    done_d    = grant_oh;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, round-robin pointer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= IDW'(NREQ - 1);
            grant_id    <= '0;
            tx_din      <= '0;
            ack         <= '0;
            done        <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_id    <= grant_d;
            tx_din      <= tx_din_d;
            ack         <= ack_d;
            done        <= done_d;
            tx_start    <= tx_start_d;
            busy        <= busy_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table for arbitration/spurious ticks, plus
// hand sequences for long waits, reset mid-WAIT, continuous round-robin and the WAIT timeout.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din_flat;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT_CYC(50)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .din_flat     (din_flat),
        .ack          (ack),
        .done         (done),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       tick;
        logic [3:0] ack;
        logic [3:0] done;
        logic       start;
        logic       busy;
        logic [1:0] gid;
        logic [7:0] din;
    } vec_t;

    vec_t tbl [12];
    logic [7:0] bytes [4];

    // {ack, done, tx_start, busy, timeout_err, grant_id, tx_din}
    function automatic logic [20:0] snap();
        return {ack, done, tx_start, busy, timeout_err, grant_id, tx_din};
    endfunction

    function automatic logic [20:0] pack(input logic [3:0] a, input logic [3:0] d, input logic s,
                                         input logic b, input logic t, input logic [1:0] g,
                                         input logic [7:0] x);
        return {a, d, s, b, t, g, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int to_cnt, to_cyc, dn_cnt, dn_cyc;
    logic [3:0] oh;
    int order [6];

    initial begin
        reset        = 1'b1;
        req          = 4'b0000;
        tx_done_tick = 1'b0;
        bytes[0] = 8'hA5; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        din_flat = {bytes[3], bytes[2], bytes[1], bytes[0]};

        // req, tick, ack, done, start, busy, gid, din (observed after the edge)
        tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h22};
        tbl[1]  = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22};
        tbl[2]  = '{4'b1000, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd1, 8'h22};
        tbl[3]  = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h44};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h44};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'd3, 8'h44};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h44};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h44};
        tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 8'hA5};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hA5};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 8'hA5};

        #1;
        chk("reset_async", 32'(snap()), 32'(pack(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00)));
        step(); step();
        chk("reset_hold", 32'(snap()), 32'(pack(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00)));
        reset = 1'b0;

        // Table: simultaneous requests 1010, spurious ticks in ISSUE and IDLE, plain request.
        for (int i = 0; i < 12; i++) begin
            req          = tbl[i].req;
            tx_done_tick = tbl[i].tick;
            step();
            chk($sformatf("vec%0d", i), 32'(snap()),
                32'(pack(tbl[i].ack, tbl[i].done, tbl[i].start, tbl[i].busy, 1'b0, tbl[i].gid, tbl[i].din)));
        end
        tx_done_tick = 1'b0;

        // Single request, tick 20 cycles after tx_start.
        req = 4'b0001;
        step();
        chk("single_issue", 32'(snap()), 32'(pack(4'b0001, 4'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5)));
        req = 4'b0000;
        for (int c = 2; c <= 21; c++) begin
            step();
            if (c == 2 || c == 21)
                chk($sformatf("single_wait_c%0d", c), 32'(snap()),
                    32'(pack(4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'hA5)));
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("single_done", 32'(snap()), 32'(pack(4'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'hA5)));
        step();
        chk("single_idle", 32'(snap()), 32'(pack(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'hA5)));

        // Reset in the middle of WAIT.
        req = 4'b0100;
        step();
        chk("rst_issue", 32'(snap()), 32'(pack(4'b0100, 4'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h33)));
        req = 4'b0000;
        step(); step();
        reset = 1'b1;
        #1;
        chk("rst_immediate", 32'(snap()), 32'(pack(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00)));
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        step();
        chk("rst_no_done", 32'(snap()), 32'(pack(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00)));
        reset = 1'b0;
        req = 4'b1000;
        step();
        chk("rst_regrant3", 32'(snap()), 32'(pack(4'b1000, 4'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h44)));
        req = 4'b0000;
        step();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("rst_regrant_done", 32'({done, busy}), 32'({4'b1000, 1'b0}));

        // Continuous requests: round-robin 0,1,2,3,0,1 and a 2-cycle tick-to-start gap.
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 1;
        req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            oh = 4'b0001 << order[g];
            step();
            chk($sformatf("cont_start%0d", g), 32'(snap()),
                32'(pack(oh, 4'b0, 1'b1, 1'b1, 1'b0, 2'(order[g]), bytes[order[g]])));
            step(); step();
            tx_done_tick = 1'b1;
            if (g == 5) req = 4'b0000;
            step();
            tx_done_tick = 1'b0;
            chk($sformatf("cont_done%0d", g), 32'({done, tx_start, busy}), 32'({oh, 1'b0, 1'b0}));
        end
        step();
        chk("cont_end_idle", 32'({tx_start, busy}), 32'(2'b00));

        // WAIT with no tick: aborts only when the timeout feature is built in.
        req = 4'b0100;
        step();
        chk("to_issue", 32'(snap()), 32'(pack(4'b0100, 4'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h33)));
        req = 4'b0000;
        to_cnt = 0; to_cyc = 0; dn_cnt = 0; dn_cyc = 0;
        for (int c = 2; c <= 60; c++) begin
            step();
            if (timeout_err) begin to_cnt++; to_cyc = c; end
            if (done != 4'b0000) begin dn_cnt++; dn_cyc = c; end
            if (timeout_err && done != 4'b0100) begin
                chk("to_done_with_err", 32'(done), 32'(4'b0100));
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("to_err_count", 32'(to_cnt), 32'd1);
        chk("to_err_cycle", 32'(to_cyc), 32'd52);
        chk("to_done_count", 32'(dn_cnt), 32'd1);
        chk("to_done_cycle", 32'(dn_cyc), 32'd52);
        chk("to_busy_low", 32'(busy), 32'd0);
`else
        chk("noto_err_count", 32'(to_cnt), 32'd0);
        chk("noto_done_count", 32'(dn_cnt), 32'd0);
        chk("noto_busy_high", 32'(busy), 32'd1);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("noto_tick_done", 32'({done, timeout_err, busy}), 32'({4'b0100, 1'b0, 1'b0}));
`endif
        // Arbitration resumes from pointer 2: requester 0 wins.
        req = 4'b0001;
        step();
        chk("resume_issue", 32'(snap()), 32'(pack(4'b0001, 4'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5)));
        req = 4'b0000;
        step();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("resume_done", 32'({done, timeout_err, busy}), 32'({4'b0001, 1'b0, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
